// File: rtl/resp_checker.sv
// resp_checker: receiving end of a bench's expected/actual stream.
// Delays {valid, expected} by LATENCY cycles so they line up with the DUT's
// actual output. Counts compares and mismatches, captures the first failing
// sample, and reports pass/fail once a programmed number of compares is done.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start, total      begin a run of 'total' compares (accepted in IDLE/DONE)
//   valid, expected   golden sample for this cycle
//   actual            DUT output, compared LATENCY cycles after its valid
//   busy, done, pass  registered state decodes (RUN, DONE, DONE && no errors)
//   cmp_count         compares performed this run
//   err_count         mismatches this run, saturating
//   first_err_idx     compare index (0-based) of the first mismatch
//   first_err_exp     delayed expected value at the first mismatch
//   first_err_act     actual value at the first mismatch
module resp_checker #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] total,
  input  logic             valid,
  input  logic [WIDTH-1:0] expected,
  input  logic [WIDTH-1:0] actual,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] cmp_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_act
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] total_q;
  logic [CNT_W-1:0] total_d;
  logic [CNT_W-1:0] cmp_d;
  logic [CNT_W-1:0] err_d;
  logic [CNT_W-1:0] fidx_d;
  logic [CNT_W-1:0] cmp_inc;
  logic [WIDTH-1:0] fexp_d;
  logic [WIDTH-1:0] fact_d;
  logic [WIDTH-1:0] d_exp;
  logic             d_valid;
  logic             mismatch;
  logic             accept_start;

  // A start is only honoured outside RUN; it also flushes the delay line.
  assign accept_start = start && ((state_q == IDLE) || (state_q == DONE));

  // Expected-value delay line aligning each golden sample with its actual.
  generate
    if (LATENCY == 0) begin : g_nodelay
      assign d_valid = valid;
      assign d_exp   = expected;
    end else begin : g_delay
      logic [LATENCY-1:0] dv_q;
      logic [WIDTH-1:0]   de_q [LATENCY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dv_q <= '0;
          for (int unsigned i = 0; i < LATENCY; i++) begin
            de_q[i] <= '0;
          end
        end else begin
          // Valid bits are cleared on start, so the start-cycle valid and
          // anything still in flight from the previous run never compare.
          dv_q[0] <= valid && !accept_start;
          de_q[0] <= expected;
          for (int unsigned i = 1; i < LATENCY; i++) begin
            dv_q[i] <= dv_q[i-1] && !accept_start;
            de_q[i] <= de_q[i-1];
          end
        end
      end

      assign d_valid = dv_q[LATENCY-1];
      assign d_exp   = de_q[LATENCY-1];
    end
  endgenerate

  // Next-state and next-counter logic.
  always_comb begin
    state_d  = state_q;
    total_d  = total_q;
    cmp_d    = cmp_count;
    err_d    = err_count;
    fidx_d   = first_err_idx;
    fexp_d   = first_err_exp;
    fact_d   = first_err_act;
    cmp_inc  = cmp_count + CNT_W'(1);
    mismatch = d_valid && (d_exp != actual);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          total_d = total;
          cmp_d   = '0;
          err_d   = '0;
          fidx_d  = '0;
          fexp_d  = '0;
          fact_d  = '0;
          state_d = (total == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (d_valid) begin
          cmp_d = cmp_inc;
          if (mismatch) begin
            if (err_count == '0) begin
              fidx_d = cmp_count;
              fexp_d = d_exp;
              fact_d = actual;
            end
            if (err_count != CNT_MAX) begin
              err_d = err_count + CNT_W'(1);
            end
          end
          if (cmp_inc == total_q) begin
            state_d = DONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      total_q       <= '0;
      cmp_count     <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_act <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else begin
      state_q       <= state_d;
      total_q       <= total_d;
      cmp_count     <= cmp_d;
      err_count     <= err_d;
      first_err_idx <= fidx_d;
      first_err_exp <= fexp_d;
      first_err_act <= fact_d;
      busy          <= (state_d == RUN);
      done          <= (state_d == DONE);
      pass          <= (state_d == DONE) && (err_d == '0);
    end
  end

endmodule

// File: doc/resp_checker.md
Name: resp_checker

Overview:
- Sequential response checker for self-checking benches: the receiving end of the stimulus/expected-value stream a bench produces.
- Takes a per-sample expected value and the DUT's actual output, and aligns expected to actual through a LATENCY-deep delay line.
- Counts compares and mismatches, and captures the first failing sample.
- Reports pass/fail after a programmed number of compares. Replaces per-cycle combinational asserts where DUT latency is nonzero.

Parameters:
- WIDTH, 1, bit width of expected/actual samples.
- LATENCY, 1, cycles between a sample's valid/expected and the matching actual; legal 0..15.
- CNT_W, 16, width of all counters and indices.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a check run; sampled only in IDLE or DONE.
- total  in  CNT_W  number of compares in the run; captured on accepted start.
- valid  in  1  expected is meaningful this cycle.
- expected  in  WIDTH  golden value for this cycle's sample.
- actual  in  WIDTH  DUT output; compared LATENCY cycles after its valid.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  high in DONE when err_count==0.
- cmp_count  out  CNT_W  compares performed this run.
- err_count  out  CNT_W  mismatches this run; saturates at all-ones.
- first_err_idx  out  CNT_W  cmp_count value (0-based) of the first mismatch.
- first_err_exp  out  WIDTH  delayed expected at the first mismatch.
- first_err_act  out  WIDTH  actual at the first mismatch.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All outputs 0.
  - Delay line cleared (valid stages 0).
- Delay line:
  - LATENCY stages of {valid, expected}, shifting every cycle.
  - d_valid/d_exp are the last stage. LATENCY=0 means d_valid=valid and d_exp=expected combinationally.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 captures total, clears cmp_count, err_count and first_err_*, and clears the delay-line valid bits.
  - If total==0, go to DONE (pass=1). Otherwise go to RUN.
  - A valid asserted in the start cycle is discarded.
- RUN:
  - On each cycle with d_valid=1, compare actual against d_exp bitwise and increment cmp_count.
  - On mismatch:
    - err_count increments, saturating.
    - If it was 0 before this cycle, capture first_err_idx = old cmp_count, first_err_exp = d_exp, first_err_act = actual.
  - When the incremented cmp_count equals total, go to DONE on the same edge.
  - start is ignored in RUN.
- DONE:
  - done=1. pass = (err_count==0), registered.
  - All counters and capture registers hold. valid/actual are ignored.
  - start=1 behaves as in IDLE (restart).
- Output timing:
  - busy, done and pass are registered state decodes, visible the cycle after the transition edge.
  - Counters update on the edge of the compare.
- Valids in flight at DONE entry are dropped. They are not counted and are flushed by the next start.
- No reset mid-run other than rst_n. Asserting rst_n low during RUN immediately returns all outputs to 0 and the state to IDLE.
- Multi-bit samples: any differing bit counts as one mismatch.

Test Plan:
- WIDTH=1, LATENCY=1, start with total=4; drive valid=1 and expected=1,0,1,1 on consecutive cycles; actual echoes expected one cycle later → done=1, pass=1, cmp_count=4, err_count=0.
- WIDTH=8, LATENCY=2, total=5, expected=0x10..0x14; corrupt actual for sample 2 (0x12→0x13) and sample 4 (0x14→0x00) → err_count=2, first_err_idx=2, first_err_exp=0x12, first_err_act=0x13, pass=0.
- total=0 start → next cycle done=1, pass=1, busy never high, cmp_count=0.
- Gapped valid (1,0,0,1,0,1) with total=3, LATENCY=3 → exactly 3 compares counted, and DONE is entered on the edge of the third delayed valid.
- rst_n pulsed low mid-run after 2 of 6 compares → outputs 0 immediately; a new start with total=2 then completes with cmp_count=2, with no leftover compares from the stale pipeline.
- CNT_W=2, total=3, all mismatching → err_count=3 (saturated at max). Restart from DONE with matching data → pass=1, err_count=0, and first_err_* cleared.
